picosoc_iomem_arbiter: RTL and testbench
========================================

PICOSOC_IOMEM_ARBITER -- requirements
Module: picosoc_iomem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of cycles a granted transaction may wait for slave ready (range 2..65535).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hFFFF_FFFF, meaning the read data returned on a timed-out transaction.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock (a2bus_if.clk_logic domain).
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 m0_valid_i  input  1  CPU (master 0) request, held until m0_ready_o.
REQ-006 m0_wstrb_i  input  4  byte-write strobes; 0 = read.
REQ-007 m0_addr_i  input  32  byte address.
REQ-008 m0_wdata_i  input  32  write data.
REQ-009 m0_rdata_o  output  32  read data.
REQ-010 m0_ready_o  output  1  transfer-complete strobe.
REQ-011 m1_valid_i, m1_wstrb_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_ready_o  same directions and widths as m0  DMA/disk-engine master (master 1).
REQ-012 s_valid_o  output  1; s_wstrb_o  output  4; s_addr_o  output  32; s_wdata_o  output  32  request to the shared iomem decoder.
REQ-013 s_rdata_i  input  32; s_ready_i  input  1  response from the shared iomem decoder.
REQ-014 timeout_o  output  1  sticky flag: at least one timeout has occurred.
REQ-015 timeout_count_o  output  8  saturating timeout count.
REQ-016 timeout_clr_i  input  1  synchronous clear of timeout_o and timeout_count_o.

Function
REQ-017 SHALL implement states IDLE, BUSY0, BUSY1.
REQ-018 IDLE: if exactly one master is valid, go to that master's BUSY state; if both are valid, grant the master not marked by last_grant; if neither is valid, stay in IDLE.
REQ-019 On entry to BUSYn, SHALL register the granted master's wstrb/addr/wdata; s_valid_o SHALL be 1 on the first BUSY cycle, giving exactly 1 cycle from request to slave valid.
REQ-020 In BUSYn, s_valid_o=1 and s_* SHALL carry the latched values; the master's inputs SHALL NOT be re-sampled.
REQ-021 In BUSYn, mn_ready_o SHALL equal s_ready_i combinationally and mn_rdata_o SHALL equal s_rdata_i; the other master SHALL see ready=0 and rdata=0.
REQ-022 On s_ready_i=1 in BUSYn: next state IDLE, last_grant<=n, and the timer cleared; at least one IDLE cycle separates any two transactions.
REQ-023 Timer: cleared on BUSY entry and incremented each BUSY cycle without s_ready_i; when it equals TIMEOUT_CYCLES-1 and s_ready_i=0, SHALL assert mn_ready_o=1 with mn_rdata_o=ERR_RDATA for that one cycle, force s_valid_o=0 on the following cycle, and go to IDLE.
REQ-024 If s_ready_i arrives on the same cycle as the timeout, the slave response SHALL win: no error is reported and no count is taken.
REQ-025 On timeout: timeout_o<=1 and timeout_count_o<=timeout_count_o+1, saturating at 8'hFF; if timeout_clr_i occurs on the same cycle, the clear SHALL win.
REQ-026 If a master drops valid during BUSY, the transaction SHALL still complete to the slave; the ready strobe is delivered regardless.
REQ-027 Timer width SHALL be $clog2(TIMEOUT_CYCLES)+1 bits; no wrap is possible.

Reset
REQ-028 Asynchronous assertion of resetn SHALL put the block in: state IDLE, last_grant=1 (so master 0 wins the first tie), timer 0, s_valid_o=0, s_wstrb_o=0, s_addr_o=0, s_wdata_o=0, m*_ready_o=0, m*_rdata_o=0, timeout_o=0, timeout_count_o=0.
REQ-029 Reset asserted mid-transaction SHALL abort the transaction without generating a ready strobe.

Structure
REQ-030 The state enum (IDLE/BUSY0/BUSY1) and the default ERR_RDATA constant SHALL live in a shared package, picosoc_pkg.
REQ-031 The timer and sticky counter MAY be a single sub-module, picosoc_bus_timer; everything else is flat.

Verification
REQ-032 Single m0 read, slave ready 3 cycles after s_valid_o, rdata 32'h1234_5678 -> s_valid_o 1 cycle after request; m0_ready_o one cycle with rdata 32'h1234_5678; m1_ready_o stays 0.
REQ-033 m0 and m1 assert valid on the same cycle, repeated 4 times -> grants alternate m0, m1, m0, m1 starting with m0.
REQ-034 m1 write (wstrb 4'hF, addr 32'h0700_0010); m1 changes addr during BUSY1 -> s_addr_o stays 32'h0700_0010 until ready.
REQ-035 TIMEOUT_CYCLES=16, slave never ready -> m0_ready_o at the 16th BUSY cycle with rdata 32'hFFFF_FFFF; timeout_o=1; count=1; 256 further timeouts -> count 8'hFF; timeout_clr_i -> both 0.
REQ-036 s_ready_i on the same cycle as the timeout -> real rdata returned, timeout_o remains 0.
REQ-037 resetn pulsed low during BUSY1 -> all outputs 0 immediately; no ready strobe; next tie grants m0.

Source files
------------

// File: rtl/picosoc_pkg.sv
// Shared types and constants for the picosoc iomem arbiter.
// Holds the arbiter state encoding and the default error read data.
package picosoc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/picosoc_bus_timer.sv
// Slave-ready watchdog for the iomem arbiter.
// Counts stalled BUSY cycles and keeps a sticky, saturating timeout tally.
module picosoc_bus_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_busy,
    input  logic       i_done,
    input  logic       i_clr,
    output logic       o_expire,
    output logic       o_timeout,
    output logic [7:0] o_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_timer;
    logic          r_timeout;
    logic [7:0]    r_count;
    logic          w_expire;

    // A slave response on the last cycle takes priority over the timeout.
    assign w_expire  = i_busy & ~i_done & (r_timer == LAST);
    assign o_expire  = w_expire;
    assign o_timeout = r_timeout;
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
        end else if (!i_busy || i_done || w_expire) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timeout <= 1'b0;
            r_count   <= 8'h00;
        end else if (i_clr) begin
            r_timeout <= 1'b0;
            r_count   <= 8'h00;
        end else if (w_expire) begin
            r_timeout <= 1'b1;
            if (r_count != 8'hFF) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/picosoc_iomem_arbiter.sv
// Two-master round-robin arbiter in front of the shared iomem decoder.
// Latches the granted request and guards the slave with a ready timeout.
module picosoc_iomem_arbiter
    import picosoc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid_i,
    input  logic [3:0]  m0_wstrb_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ready_o,
    input  logic        m1_valid_i,
    input  logic [3:0]  m1_wstrb_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ready_o,
    output logic        s_valid_o,
    output logic [3:0]  s_wstrb_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i,
    input  logic        s_ready_i,
    output logic        timeout_o,
    output logic [7:0]  timeout_count_o,
    input  logic        timeout_clr_i
);

    arb_state_t  r_state;
    logic        r_last_grant;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_busy;
    logic        w_expire;
    logic        w_end;
    logic [31:0] w_rsp_data;

    assign w_busy     = (r_state != IDLE);
    assign w_end      = s_ready_i | w_expire;
    assign w_rsp_data = w_expire ? ERR_RDATA : s_rdata_i;

    assign s_valid_o = w_busy;
    assign s_wstrb_o = r_wstrb;
    assign s_addr_o  = r_addr;
    assign s_wdata_o = r_wdata;

    assign m0_ready_o = (r_state == BUSY0) & w_end;
    assign m1_ready_o = (r_state == BUSY1) & w_end;
    assign m0_rdata_o = (r_state == BUSY0) ? w_rsp_data : 32'h0;
    assign m1_rdata_o = (r_state == BUSY1) ? w_rsp_data : 32'h0;

    picosoc_bus_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .i_busy   (w_busy),
        .i_done   (s_ready_i),
        .i_clr    (timeout_clr_i),
        .o_expire (w_expire),
        .o_timeout(timeout_o),
        .o_count  (timeout_count_o)
    );

    // last_grant resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_wstrb      <= 4'h0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (m0_valid_i && (!m1_valid_i || r_last_grant)) begin
                        r_state <= BUSY0;
                        r_wstrb <= m0_wstrb_i;
                        r_addr  <= m0_addr_i;
                        r_wdata <= m0_wdata_i;
                    end else if (m1_valid_i) begin
                        r_state <= BUSY1;
                        r_wstrb <= m1_wstrb_i;
                        r_addr  <= m1_addr_i;
                        r_wdata <= m1_wdata_i;
                    end
                end
                BUSY0: begin
                    if (w_end) begin
                        r_state      <= IDLE;
                        r_last_grant <= 1'b0;
                    end
                end
                BUSY1: begin
                    if (w_end) begin
                        r_state      <= IDLE;
                        r_last_grant <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picosoc_iomem_arbiter.sv
// Directed self-checking bench for picosoc_iomem_arbiter.
// Uses TIMEOUT_CYCLES=16 so the watchdog paths are reachable quickly.
module tb_picosoc_iomem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid_i, m1_valid_i;
    logic [3:0]  m0_wstrb_i, m1_wstrb_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        m0_ready_o, m1_ready_o;
    logic        s_valid_o;
    logic [3:0]  s_wstrb_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [31:0] s_rdata_i;
    logic        s_ready_i;
    logic        timeout_o;
    logic [7:0]  timeout_count_o;
    logic        timeout_clr_i;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    picosoc_iomem_arbiter #(
        .TIMEOUT_CYCLES(16),
        .ERR_RDATA     (32'hFFFF_FFFF)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .m0_valid_i     (m0_valid_i),
        .m0_wstrb_i     (m0_wstrb_i),
        .m0_addr_i      (m0_addr_i),
        .m0_wdata_i     (m0_wdata_i),
        .m0_rdata_o     (m0_rdata_o),
        .m0_ready_o     (m0_ready_o),
        .m1_valid_i     (m1_valid_i),
        .m1_wstrb_i     (m1_wstrb_i),
        .m1_addr_i      (m1_addr_i),
        .m1_wdata_i     (m1_wdata_i),
        .m1_rdata_o     (m1_rdata_o),
        .m1_ready_o     (m1_ready_o),
        .s_valid_o      (s_valid_o),
        .s_wstrb_o      (s_wstrb_o),
        .s_addr_o       (s_addr_o),
        .s_wdata_o      (s_wdata_o),
        .s_rdata_i      (s_rdata_i),
        .s_ready_i      (s_ready_i),
        .timeout_o      (timeout_o),
        .timeout_count_o(timeout_count_o),
        .timeout_clr_i  (timeout_clr_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic to_txn();
        m0_valid_i = 1'b1;
        cyc();
        repeat (15) cyc();
        cyc();
        m0_valid_i = 1'b0;
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        m0_valid_i = 0; m0_wstrb_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
        m1_valid_i = 0; m1_wstrb_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
        s_rdata_i = 0; s_ready_i = 0; timeout_clr_i = 0;
        #3;
        chk("rst_s_valid", 32'(s_valid_o), 32'h0);
        chk("rst_s_addr", s_addr_o, 32'h0);
        chk("rst_tmo", {23'h0, timeout_o, timeout_count_o}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        cyc();

        // ties: both masters held valid, grants must alternate from m0
        m0_addr_i = 32'h0000_1000;
        m1_addr_i = 32'h0000_2000;
        m0_valid_i = 1'b1;
        m1_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("tie_addr", s_addr_o,
                (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            s_ready_i = 1'b1;
            s_rdata_i = 32'(i + 32'hA0);
            #1;
            chk("tie_rdy", {30'h0, m1_ready_o, m0_ready_o},
                (i % 2 == 0) ? 32'h1 : 32'h2);
            cyc();
            s_ready_i = 1'b0;
            #1;
            chk("tie_gap", 32'(s_valid_o), 32'h0);
        end
        m0_valid_i = 1'b0;
        m1_valid_i = 1'b0;
        cyc();

        // single m0 read, slave ready on the 4th BUSY cycle
        m0_valid_i = 1'b1;
        m0_wstrb_i = 4'h0;
        m0_addr_i  = 32'h0200_0004;
        #1;
        chk("rd_idle_valid", 32'(s_valid_o), 32'h0);
        cyc();
        chk("rd_s_valid", 32'(s_valid_o), 32'h1);
        chk("rd_s_addr", s_addr_o, 32'h0200_0004);
        repeat (3) begin
            chk("rd_wait_rdy", 32'(m0_ready_o), 32'h0);
            cyc();
        end
        s_ready_i = 1'b1;
        s_rdata_i = 32'h1234_5678;
        #1;
        chk("rd_m0_rdy", 32'(m0_ready_o), 32'h1);
        chk("rd_m0_rdata", m0_rdata_o, 32'h1234_5678);
        chk("rd_m1_rdy", 32'(m1_ready_o), 32'h0);
        cyc();
        s_ready_i = 1'b0;
        m0_valid_i = 1'b0;
        #1;
        chk("rd_done_rdy", {30'h0, m1_ready_o, m0_ready_o}, 32'h0);
        chk("rd_done_valid", 32'(s_valid_o), 32'h0);

        // m1 write, address changes while BUSY1
        m1_valid_i = 1'b1;
        m1_wstrb_i = 4'hF;
        m1_addr_i  = 32'h0700_0010;
        m1_wdata_i = 32'hDEAD_BEEF;
        cyc();
        chk("wr_wstrb", 32'(s_wstrb_o), 32'hF);
        chk("wr_wdata", s_wdata_o, 32'hDEAD_BEEF);
        m1_addr_i  = 32'h0700_0020;
        m1_wdata_i = 32'h0BAD_0BAD;
        m1_wstrb_i = 4'h1;
        cyc();
        chk("wr_addr_hold1", s_addr_o, 32'h0700_0010);
        cyc();
        chk("wr_addr_hold2", s_addr_o, 32'h0700_0010);
        chk("wr_wdata_hold", s_wdata_o, 32'hDEAD_BEEF);
        s_ready_i = 1'b1;
        s_rdata_i = 32'hAAAA_5555;
        #1;
        chk("wr_m1_rdy", 32'(m1_ready_o), 32'h1);
        chk("wr_m1_rdata", m1_rdata_o, 32'hAAAA_5555);
        chk("wr_m0_rdy", 32'(m0_ready_o), 32'h0);
        chk("wr_m0_rdata", m0_rdata_o, 32'h0);
        cyc();
        s_ready_i = 1'b0;
        m1_valid_i = 1'b0;
        m1_wstrb_i = 4'h0;

        // first timeout, slave never ready
        m0_valid_i = 1'b1;
        m0_addr_i  = 32'h0300_0000;
        cyc();
        chk("to_s_valid", 32'(s_valid_o), 32'h1);
        repeat (14) cyc();
        chk("to_pre_rdy", 32'(m0_ready_o), 32'h0);
        cyc();
        chk("to_rdy", 32'(m0_ready_o), 32'h1);
        chk("to_rdata", m0_rdata_o, 32'hFFFF_FFFF);
        cyc();
        m0_valid_i = 1'b0;
        #1;
        chk("to_after_valid", 32'(s_valid_o), 32'h0);
        chk("to_flag", 32'(timeout_o), 32'h1);
        chk("to_count1", 32'(timeout_count_o), 32'h1);

        repeat (253) to_txn();
        chk("to_count254", 32'(timeout_count_o), 32'hFE);
        to_txn();
        chk("to_count255", 32'(timeout_count_o), 32'hFF);
        repeat (2) to_txn();
        chk("to_count_sat", 32'(timeout_count_o), 32'hFF);

        timeout_clr_i = 1'b1;
        cyc();
        timeout_clr_i = 1'b0;
        chk("clr_flag", 32'(timeout_o), 32'h0);
        chk("clr_count", 32'(timeout_count_o), 32'h0);

        // slave ready on the timeout cycle wins
        m0_valid_i = 1'b1;
        cyc();
        repeat (15) cyc();
        s_ready_i = 1'b1;
        s_rdata_i = 32'h5555_AAAA;
        #1;
        chk("race_rdy", 32'(m0_ready_o), 32'h1);
        chk("race_rdata", m0_rdata_o, 32'h5555_AAAA);
        cyc();
        s_ready_i = 1'b0;
        m0_valid_i = 1'b0;
        chk("race_flag", 32'(timeout_o), 32'h0);
        chk("race_count", 32'(timeout_count_o), 32'h0);

        // clear coincident with a timeout wins
        m0_valid_i = 1'b1;
        cyc();
        repeat (15) cyc();
        timeout_clr_i = 1'b1;
        #1;
        chk("clrwin_rdy", 32'(m0_ready_o), 32'h1);
        cyc();
        timeout_clr_i = 1'b0;
        m0_valid_i = 1'b0;
        chk("clrwin_flag", 32'(timeout_o), 32'h0);
        chk("clrwin_count", 32'(timeout_count_o), 32'h0);

        // reset pulse during BUSY1
        m1_valid_i = 1'b1;
        m1_wstrb_i = 4'h3;
        m1_addr_i  = 32'h0400_0008;
        m1_wdata_i = 32'h0000_CAFE;
        cyc();
        chk("rb_busy", 32'(s_valid_o), 32'h1);
        resetn = 1'b0;
        s_ready_i = 1'b1;
        s_rdata_i = 32'h1111_2222;
        #1;
        chk("rb_s_valid", 32'(s_valid_o), 32'h0);
        chk("rb_s_addr", s_addr_o, 32'h0);
        chk("rb_s_wdata", s_wdata_o, 32'h0);
        chk("rb_s_wstrb", 32'(s_wstrb_o), 32'h0);
        chk("rb_rdy", {30'h0, m1_ready_o, m0_ready_o}, 32'h0);
        chk("rb_m1_rdata", m1_rdata_o, 32'h0);
        s_ready_i = 1'b0;
        m1_valid_i = 1'b0;
        #1;
        resetn = 1'b1;
        cyc();
        chk("rb_idle", 32'(s_valid_o), 32'h0);
        m0_addr_i  = 32'h0000_1000;
        m1_addr_i  = 32'h0000_2000;
        m0_valid_i = 1'b1;
        m1_valid_i = 1'b1;
        cyc();
        chk("rb_tie_addr", s_addr_o, 32'h0000_1000);
        s_ready_i = 1'b1;
        #1;
        chk("rb_tie_rdy", {30'h0, m1_ready_o, m0_ready_o}, 32'h1);
        cyc();
        s_ready_i = 1'b0;
        m0_valid_i = 1'b0;
        m1_valid_i = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
